// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised FIFO and its storage array.
package fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Smallest r with 2**r >= value; sizes the count (DEPTH+1) and pointer (DEPTH) fields.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read address.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter  int FIFO_WIDTH = 16,
    parameter  int FIFO_DEPTH = 8,
    localparam int AW         = clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [FIFO_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [FIFO_WIDTH-1:0] o_rdata
);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];

    // Contents deliberately carry no reset; occupancy tracking makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with occupancy flags, one-cycle status pulses and selectable read mode.
module param_fifo
    import fifo_pkg::*;
#(
    parameter  int FIFO_WIDTH = 16,
    parameter  int FIFO_DEPTH = 8,
    parameter  int AF_THRESH  = FIFO_DEPTH - 1,
    parameter  int AE_THRESH  = 1,
    parameter  int FWFT       = FWFT_OFF,
    localparam int CW         = clog2(FIFO_DEPTH + 1),
    localparam int AW         = clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CW-1:0]         count
);

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [FIFO_WIDTH-1:0] w_mem_rdata;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == AW'(FIFO_DEPTH - 1)) ? '0 : ptr + AW'(1);
    endfunction

    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
        end
    end

    fifo_mem #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    if (FWFT == FWFT_ON) begin : g_fwft
        assign data_out = w_mem_rdata;
    end else begin : g_reg
        logic [FIFO_WIDTH-1:0] r_data_out;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_data_out <= '0;
            end else if (w_rd_acc) begin
                r_data_out <= w_mem_rdata;
            end
        end

        assign data_out = r_data_out;
    end

    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (int'(r_count) >= AF_THRESH);
    assign almostempty = (int'(r_count) <= AE_THRESH);
    assign count       = r_count;

endmodule

// File: tb/tb_param_fifo.sv
// Three FIFO configurations driven by shared stimulus, each checked against a queue model.
module tb_param_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] din;

    wire  [15:0] dout_v [3];
    wire  [3:0]  cnt_v  [3];
    wire  [2:0]  ack_v, ovf_v, udf_v, full_v, empty_v, af_v, ae_v;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
        end
    endtask

    // Instance 0: depth 8 registered; 1: depth 5 registered; 2: depth 8 FWFT, AF=6, AE=2.
    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int D  = (g == 1) ? 5 : 8;
        localparam int FW = (g == 2) ? 1 : 0;
        localparam int AF = (g == 2) ? 6 : D - 1;
        localparam int AE = (g == 2) ? 2 : 1;
        localparam int CW = $clog2(D + 1);

        logic [CW-1:0] cnt_l;
        logic [15:0]   dout_l;

        param_fifo #(
            .FIFO_WIDTH (16),
            .FIFO_DEPTH (D),
            .AF_THRESH  (AF),
            .AE_THRESH  (AE),
            .FWFT       (FW)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .data_in     (din),
            .wr_en       (wr_en),
            .rd_en       (rd_en),
            .data_out    (dout_l),
            .wr_ack      (ack_v[g]),
            .overflow    (ovf_v[g]),
            .underflow   (udf_v[g]),
            .full        (full_v[g]),
            .empty       (empty_v[g]),
            .almostfull  (af_v[g]),
            .almostempty (ae_v[g]),
            .count       (cnt_l)
        );

        assign cnt_v[g]  = 4'(cnt_l);
        assign dout_v[g] = dout_l;

        logic [15:0] q [$];
        logic [15:0] m_dout = '0;
        logic        m_ack  = 1'b0;
        logic        m_ovf  = 1'b0;
        logic        m_udf  = 1'b0;
        bit          armed  = 1'b0;

        always @(posedge clk) begin
            bit was_full;
            bit was_empty;
            if (rst) begin
                q.delete();
                m_dout = '0;
                m_ack  = 1'b0;
                m_ovf  = 1'b0;
                m_udf  = 1'b0;
                armed  = 1'b1;
            end else begin
                was_full  = (q.size() == D);
                was_empty = (q.size() == 0);
                m_ack = wr_en && !was_full;
                m_ovf = wr_en && was_full;
                m_udf = rd_en && was_empty;
                if (rd_en && !was_empty) begin
                    m_dout = q.pop_front();
                end
                if (m_ack) begin
                    q.push_back(din);
                end
            end
        end

        always @(negedge clk) begin
            string p;
            if (armed) begin
                p = $sformatf("i%0d_", g);
                chk({p, "count"}, 32'(cnt_l), q.size());
                chk({p, "full"},  full_v[g],  q.size() == D);
                chk({p, "empty"}, empty_v[g], q.size() == 0);
                chk({p, "afull"}, af_v[g],    q.size() >= AF);
                chk({p, "aempty"}, ae_v[g],   q.size() <= AE);
                chk({p, "wr_ack"}, ack_v[g],  m_ack);
                chk({p, "ovf"},   ovf_v[g],   m_ovf);
                chk({p, "udf"},   udf_v[g],   m_udf);
                if (FW == 0 || q.size() != 0) begin
                    chk({p, "dout"}, dout_l, (FW == 1) ? q[0] : m_dout);
                end
            end
        end
    end

    task automatic step(input logic rs, input logic w, input logic r, input logic [15:0] d);
        rst   = rs;
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acks;
        int pw;
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        step(1, 0, 0, 16'h0);
        step(1, 1, 1, 16'hFFFF);
        chk("rst_count", cnt_v[0], 0);
        chk("rst_empty", empty_v[0], 1);
        chk("rst_dout", dout_v[0], 0);

        acks = 0;
        for (int i = 1; i <= 9; i++) begin
            step(0, 1, 0, 16'(i));
            acks += int'(ack_v[0]);
        end
        chk("wr9_count", cnt_v[0], 8);
        chk("wr9_full", full_v[0], 1);
        chk("wr9_ovf", ovf_v[0], 1);
        chk("wr9_acks", acks, 8);
        chk("wr9_d5_count", cnt_v[1], 5);

        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, 16'h0);
            chk($sformatf("rd%0d_dout", i), dout_v[0], i);
        end
        step(0, 0, 1, 16'h0);
        chk("rd9_udf", udf_v[0], 1);
        chk("rd9_empty", empty_v[0], 1);
        chk("rd9_dout_hold", dout_v[0], 8);

        for (int i = 0; i < 8; i++) step(0, 1, 0, 16'(16'h100 + i));
        step(0, 1, 1, 16'h0BAD);
        chk("both_full_count", cnt_v[0], 7);
        chk("both_full_ovf", ovf_v[0], 1);
        chk("both_full_ack", ack_v[0], 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 16'h0);
        step(0, 1, 1, 16'h0C0D);
        chk("both_empty_count", cnt_v[0], 1);
        chk("both_empty_udf", udf_v[0], 1);
        chk("both_empty_ack", ack_v[0], 1);

        step(1, 0, 0, 16'h0);
        step(0, 1, 0, 16'hA5A5);
        chk("fwft_dout", dout_v[2], 16'hA5A5);
        step(0, 0, 0, 16'h0);
        chk("fwft_dout_idle", dout_v[2], 16'hA5A5);
        step(0, 1, 0, 16'h0002);
        chk("fwft_ae_at2", ae_v[2], 1);
        step(0, 1, 0, 16'h0003);
        chk("fwft_ae_at3", ae_v[2], 0);
        step(0, 1, 0, 16'h0004);
        step(0, 1, 0, 16'h0005);
        chk("fwft_af_at5", af_v[2], 0);
        step(0, 1, 0, 16'h0006);
        chk("fwft_af_at6", af_v[2], 1);

        step(1, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 16'(16'h40 + i));
        chk("pre_rst_count", cnt_v[0], 4);
        step(1, 1, 0, 16'h1234);
        chk("mid_rst_count", cnt_v[0], 0);
        chk("mid_rst_empty", empty_v[0], 1);
        chk("mid_rst_ack", ack_v[0], 0);
        chk("mid_rst_ovf", ovf_v[0], 0);
        chk("mid_rst_udf", udf_v[0], 0);

        for (int s = 0; s < 15; s++) begin
            pw = $urandom_range(20, 80);
            for (int c = 0; c < 200; c++) begin
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 99) < pw,
                     $urandom_range(0, 99) < (100 - pw),
                     16'($urandom));
            end
        end
        step(0, 0, 0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameters SHALL be declared one per line as name, default, meaning:
- FIFO_WIDTH, 16, data word width, >=1
- FIFO_DEPTH, 8, number of entries, >=2, need not be a power of two
- AF_THRESH, FIFO_DEPTH-1, almostfull asserts when count >= AF_THRESH
- AE_THRESH, 1, almostempty asserts when count <= AE_THRESH
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
REQ-002 Ports SHALL be declared one per line as name, direction, width, meaning:
- clk, in, 1, the single clock; all logic on posedge
- rst, in, 1, synchronous active-high reset
- data_in, in, FIFO_WIDTH, write data
- wr_en, in, 1, write request
- rd_en, in, 1, read request
- data_out, out, FIFO_WIDTH, read data
- wr_ack, out, 1, write accepted, one-cycle pulse
- overflow, out, 1, write rejected, one-cycle pulse
- underflow, out, 1, read rejected, one-cycle pulse
- full, out, 1, count == FIFO_DEPTH
- empty, out, 1, count == 0
- almostfull, out, 1, count >= AF_THRESH
- almostempty, out, 1, count <= AE_THRESH
- count, out, $clog2(FIFO_DEPTH+1), current occupancy

Function
REQ-003 A write SHALL be accepted iff wr_en && !full, judged on pre-edge state; an accepted write stores data_in at wr_ptr.
REQ-004 A read SHALL be accepted iff rd_en && !empty, judged on pre-edge state; an accepted read advances rd_ptr.
REQ-005 When both are accepted in one cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-006 count SHALL change by +1 on write-only accept, -1 on read-only accept, and 0 otherwise.
REQ-007 Pointers SHALL wrap from FIFO_DEPTH-1 to 0 for any depth, including non-power-of-two.
REQ-008 wr_ack SHALL be 1 in the cycle after an accepted write and 0 otherwise.
REQ-009 overflow SHALL be 1 in the cycle after a cycle with wr_en && full, regardless of rd_en, and 0 otherwise.
REQ-010 underflow SHALL be 1 in the cycle after a cycle with rd_en && empty, regardless of wr_en, and 0 otherwise.
REQ-011 With wr_en && rd_en on full, the read SHALL be accepted, the write rejected, count SHALL go to FIFO_DEPTH-1, and overflow SHALL pulse.
REQ-012 With wr_en && rd_en on empty, the write SHALL be accepted, the read rejected, count SHALL go to 1, and underflow SHALL pulse.
REQ-013 With FWFT=0, data_out SHALL register mem[rd_ptr] on an accepted read (1-cycle latency) and SHALL hold its value otherwise.
REQ-014 With FWFT=1, data_out SHALL combinationally show mem[rd_ptr] while !empty; the value is don't-care while empty. rd_en consumes the displayed word.
REQ-015 full, empty, almostfull and almostempty SHALL be combinational decodes of count only.
REQ-016 There SHALL be no write-through: a word written in cycle N is readable no earlier than cycle N+1.

Reset
REQ-017 While rst=1 at a clk edge, wr_ptr, rd_ptr and count SHALL clear to 0, and wr_ack, overflow, underflow and data_out SHALL clear to 0.
REQ-018 Reset SHALL take priority over any concurrent wr_en or rd_en; requests in the reset cycle are dropped without flags.
REQ-019 Memory contents SHALL NOT be reset; after reset the FIFO reads as empty.

Structure
REQ-020 Shared package fifo_pkg SHALL hold the read-mode constants FWFT_OFF=0 and FWFT_ON=1, plus the count-width function clog2(FIFO_DEPTH+1).
REQ-021 Storage SHALL be a sub-module fifo_mem: a 1-write, 1-read-address register array parameterised by FIFO_WIDTH and FIFO_DEPTH.
REQ-022 Pointer, count and flag logic SHALL reside in param_fifo.

Verification
REQ-023 DEPTH=8, FWFT=0: write 0x0001..0x0008 -> full=1, count=8, eight wr_ack pulses; a 9th write -> overflow pulse, count stays 8.
REQ-024 DEPTH=8, FWFT=0: read 8 times from full -> data_out 0x0001..0x0008 each one cycle after rd_en; a 9th read -> underflow pulse, empty=1.
REQ-025 DEPTH=5: 12 writes interleaved with 12 reads -> in-order data across pointer wrap, count never exceeds 5.
REQ-026 Full FIFO with wr_en=rd_en=1 -> count=7, overflow=1, wr_ack=0; empty FIFO with wr_en=rd_en=1 -> count=1, underflow=1, wr_ack=1.
REQ-027 FWFT=1, AF_THRESH=6, AE_THRESH=2: write 0xA5A5 -> data_out=0xA5A5 with no rd_en; count=2 -> almostempty=1; count=6 -> almostfull=1.
REQ-028 Assert rst for one cycle at count=4 with wr_en=1 -> next cycle count=0, empty=1, all pulse outputs 0.
